// File: rtl/scaler_line_fill_ctrl.sv
// Write-side sequencer for the scaler's line ring buffer: walks source coordinates,
// requests pixels, writes them into the ring slots and gates each line on read progress.
module scaler_line_fill_ctrl #(
  parameter int unsigned SRC_ACTIVE = 1024,
  parameter int unsigned SRC_HBLANK = 6,
  parameter int unsigned LINES      = 4,
  parameter int unsigned CW         = 11
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         frame_start,
  input  logic                                         frame_active,
  input  logic [CW-1:0]                                rd_line,
  input  logic                                         rd_line_strobe,
  output logic [CW-1:0]                                src_x,
  output logic [CW-1:0]                                src_y,
  output logic                                         src_req,
  output logic                                         wr_en,
  output logic [$clog2(LINES)+$clog2(SRC_ACTIVE)-1:0]  wr_addr,
  output logic                                         stall,
  output logic                                         line_done,
  output logic                                         frame_done,
  output logic                                         underrun
);

  localparam int unsigned XW = $clog2(SRC_ACTIVE);
  localparam int unsigned LW = $clog2(LINES);
  localparam int unsigned AW = LW + XW;

  localparam logic [CW-1:0] X_LAST = CW'(SRC_ACTIVE + SRC_HBLANK - 1);
  localparam logic [CW-1:0] X_ACT  = CW'(SRC_ACTIVE);
  localparam logic [CW-1:0] Y_LAST = CW'(SRC_ACTIVE - 1);
  localparam logic [CW:0]   N_ACT  = (CW+1)'(SRC_ACTIVE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GATE,
    S_FILL,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   x_q, x_d;
  logic [CW-1:0]   y_q, y_d;
  logic            line_done_q, line_done_d;
  logic            frame_done_q, frame_done_d;
  logic            underrun_q, underrun_d;
  logic            wr_en_q;
  logic [AW-1:0]   wr_addr_q;

  logic            start;
  logic            gate_ok;
  logic            req;
  logic            kill;
  logic [CW:0]     rd_plus2;
  logic [CW:0]     rd_need;

  assign start    = frame_start && frame_active;
  // Widened by one bit so rd_line+LINES never wraps near the bottom of the frame.
  assign gate_ok  = ({1'b0, y_q} < ({1'b0, rd_line} + (CW+1)'(LINES)));
  assign req      = (state_q == S_FILL) && (x_q < X_ACT);
  assign rd_plus2 = {1'b0, rd_line} + (CW+1)'(2);
  assign rd_need  = (rd_plus2 < N_ACT) ? rd_plus2 : N_ACT;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    line_done_d  = 1'b0;
    frame_done_d = 1'b0;
    underrun_d   = underrun_q;
    kill         = 1'b0;

    if (start) begin
      state_d    = S_GATE;
      x_d        = '0;
      y_d        = '0;
      underrun_d = 1'b0;
      kill       = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_GATE: begin
          if (!frame_active) begin
            state_d = S_IDLE;
            x_d     = '0;
            y_d     = '0;
          end else if (gate_ok) begin
            state_d = S_FILL;
          end
        end
        S_FILL: begin
          if (!frame_active) begin
            state_d = S_IDLE;
            x_d     = '0;
            y_d     = '0;
            kill    = 1'b1;
          end else if (x_q == X_LAST) begin
            x_d         = '0;
            y_d         = y_q + CW'(1);
            line_done_d = 1'b1;
            if (y_q == Y_LAST) begin
              state_d      = S_DONE;
              frame_done_d = 1'b1;
            end else begin
              state_d = S_GATE;
            end
          end else begin
            x_d = x_q + CW'(1);
          end
        end
        S_DONE: begin
          if (!frame_active) begin
            state_d = S_IDLE;
            x_d     = '0;
            y_d     = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // Completed-line count is src_y in both GATE and FILL.
      if (rd_line_strobe && (state_q == S_GATE || state_q == S_FILL) &&
          ({1'b0, y_q} < rd_need)) begin
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      line_done_q  <= line_done_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
      wr_en_q      <= req && !kill;
      if (req) begin
        wr_addr_q <= {y_q[LW-1:0], x_q[XW-1:0]};
      end
    end
  end

  assign src_x      = x_q;
  assign src_y      = y_q;
  assign src_req    = req;
  assign stall      = (state_q == S_GATE) && !gate_ok;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign line_done  = line_done_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_scaler_line_fill_ctrl.sv
// Directed bench for scaler_line_fill_ctrl, scaled down to 16x16 source with 6 blank cycles.
module tb_scaler_line_fill_ctrl;

  localparam int unsigned SA = 16;
  localparam int unsigned HB = 6;
  localparam int unsigned LN = 4;
  localparam int unsigned CW = 11;
  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_start;
  logic          frame_active;
  logic [CW-1:0] rd_line;
  logic          rd_line_strobe;
  logic [CW-1:0] src_x;
  logic [CW-1:0] src_y;
  logic          src_req;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          stall;
  logic          line_done;
  logic          frame_done;
  logic          underrun;

  scaler_line_fill_ctrl #(
    .SRC_ACTIVE(SA),
    .SRC_HBLANK(HB),
    .LINES     (LN),
    .CW        (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start   (frame_start),
    .frame_active  (frame_active),
    .rd_line       (rd_line),
    .rd_line_strobe(rd_line_strobe),
    .src_x         (src_x),
    .src_y         (src_y),
    .src_req       (src_req),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .stall         (stall),
    .line_done     (line_done),
    .frame_done    (frame_done),
    .underrun      (underrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Output monitor: counts pulses and checks writes land on consecutive addresses.
  int            wr_cnt   = 0;
  int            ld_cnt   = 0;
  int            fd_cnt   = 0;
  int            seq_err  = 0;
  int            seq_base = 0;
  logic [AW-1:0] last_addr = '0;

  always @(negedge clk) begin
    if (wr_en) begin
      if (wr_addr !== AW'(wr_cnt - seq_base)) seq_err++;
      last_addr = wr_addr;
      wr_cnt++;
    end
    if (line_done)  ld_cnt++;
    if (frame_done) fd_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int n, w0, l0, f0, ld, prev;

  initial begin
    frame_start    = 1'b0;
    frame_active   = 1'b0;
    rd_line        = '0;
    rd_line_strobe = 1'b0;
    rst_n          = 1'b0;
    repeat (2) tick();
    chk("rst_x",    32'(src_x), 0);
    chk("rst_y",    32'(src_y), 0);
    chk("rst_ctl",  32'({src_req, wr_en, stall, line_done, frame_done, underrun}), 0);
    chk("rst_addr", 32'(wr_addr), 0);

    rst_n = 1'b1;
    frame_active = 1'b1;
    n = 0;
    repeat (5) begin tick(); n = n + int'(src_req); end
    chk("idle_noreq", 32'(n), 0);

    // Fill the ring with lines 0..3 while rd_line stays at 0.
    w0 = wr_cnt; l0 = ld_cnt; seq_base = wr_cnt;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("gate_no_req", 32'(src_req), 0);
    tick();
    chk("first_req", 32'(src_req), 1);
    chk("first_x",   32'(src_x), 0);
    for (int i = 0; i < 600 && stall !== 1'b1; i++) tick();
    chk("full_stall", 32'(stall), 1);
    chk("full_wr",    32'(wr_cnt - w0), 64);
    chk("full_last",  32'(last_addr), 32'h3F);
    chk("full_y",     32'(src_y), 4);
    chk("full_x",     32'(src_x), 0);
    chk("full_lines", 32'(ld_cnt - l0), 4);
    repeat (5) tick();
    chk("hold_stall", 32'(stall), 1);
    chk("hold_wr",    32'(wr_cnt - w0), 64);
    chk("hold_y",     32'(src_y), 4);

    // Release one slot; strobe at the same time must not flag underrun (4 >= 1+2).
    rd_line = CW'(1);
    rd_line_strobe = 1'b1;
    #1;
    chk("release_comb", 32'(stall), 0);
    tick();
    rd_line_strobe = 1'b0;
    chk("release_req", 32'(src_req), 1);
    chk("release_x",   32'(src_x), 0);
    chk("no_underrun", 32'(underrun), 0);
    tick();
    chk("release_wr_en", 32'(wr_en), 1);
    chk("release_addr",  32'(wr_addr), 0);
    for (int i = 0; i < 200 && stall !== 1'b1; i++) tick();
    chk("stall_y5",  32'(src_y), 5);
    chk("stall_wr",  32'(wr_cnt - w0), 80);
    chk("seq_fill",  32'(seq_err), 0);

    // Underrun: 5 completed lines < rd_line(4)+2.
    rd_line = CW'(4);
    rd_line_strobe = 1'b1;
    tick();
    rd_line_strobe = 1'b0;
    chk("underrun_set", 32'(underrun), 1);
    repeat (3) tick();
    chk("underrun_sticky", 32'(underrun), 1);
    chk("refill_req",      32'(src_req), 1);

    // Restart mid-line: in-flight write dropped, underrun cleared.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("restart_underrun", 32'(underrun), 0);
    chk("restart_wr_kill",  32'(wr_en), 0);
    chk("restart_x",        32'(src_x), 0);
    chk("restart_y",        32'(src_y), 0);
    chk("restart_req",      32'(src_req), 0);

    // Full frame with the reader trailing two lines behind.
    rd_line = '0;
    w0 = wr_cnt; l0 = ld_cnt; f0 = fd_cnt; seq_base = wr_cnt; prev = 0;
    for (int i = 0; i < 1000 && fd_cnt == f0; i++) begin
      tick();
      ld = ld_cnt - l0;
      if (ld >= 2) begin
        rd_line = CW'(ld - 2);
        rd_line_strobe = (ld != prev);
      end else begin
        rd_line_strobe = 1'b0;
      end
      prev = ld;
    end
    rd_line_strobe = 1'b0;
    chk("frame_done",  32'(fd_cnt - f0), 1);
    chk("frame_wr",    32'(wr_cnt - w0), 256);
    chk("frame_lines", 32'(ld_cnt - l0), 16);
    chk("frame_seq",   32'(seq_err), 0);
    chk("frame_no_underrun", 32'(underrun), 0);
    n = 0;
    repeat (10) begin tick(); n = n + int'(src_req) + int'(stall); end
    chk("done_quiet", 32'(n), 0);
    chk("done_once",  32'(fd_cnt - f0), 1);
    chk("done_wr",    32'(wr_cnt - w0), 256);
    frame_active = 1'b0;
    tick();
    chk("idle_x", 32'(src_x), 0);
    chk("idle_y", 32'(src_y), 0);

    // frame_start without frame_active is ignored.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n = 0;
    repeat (4) begin tick(); n = n + int'(src_req); end
    chk("start_needs_active", 32'(n), 0);

    // Abort at column 14 of line 2.
    rd_line = '0;
    frame_active = 1'b1;
    w0 = wr_cnt; seq_base = wr_cnt;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 200 && !(src_y == 11'd2 && src_x == 11'd14); i++) tick();
    chk("abort_point_req", 32'(src_req), 1);
    frame_active = 1'b0;
    tick();
    chk("abort_req",     32'(src_req), 0);
    chk("abort_wr_kill", 32'(wr_en), 0);
    chk("abort_x",       32'(src_x), 0);
    chk("abort_y",       32'(src_y), 0);
    repeat (4) tick();
    chk("abort_wr",   32'(wr_cnt - w0), 46);
    chk("abort_last", 32'(last_addr), 32'h2D);
    chk("abort_seq",  32'(seq_err), 0);

    // Asynchronous reset in the middle of line 1.
    frame_active = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (30) tick();
    chk("pre_reset_req", 32'(src_req), 1);
    rst_n = 1'b0;
    #1;
    chk("async_x",    32'(src_x), 0);
    chk("async_y",    32'(src_y), 0);
    chk("async_ctl",  32'({src_req, wr_en, stall, line_done, frame_done, underrun}), 0);
    chk("async_addr", 32'(wr_addr), 0);
    tick();
    rst_n = 1'b1;
    n = 0;
    repeat (5) begin tick(); n = n + int'(src_req); end
    chk("post_reset_idle", 32'(n), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scaler_line_fill_ctrl.md
Name: scaler_line_fill_ctrl

Overview:
Write-side sequencer for the bilinear scaler's 4-line ring buffer. It generates source pixel coordinates, requests pixels from the internal video generator, and issues write enables and addresses into the line-buffer RAMs. Each new source line is gated against the line the read side currently needs, so no slot is overwritten before it is consumed. It also flags read-side underruns. It sits between the internal video generator and the scaler line-buffer RAMs, all in the scaler clock domain.

Parameters:
SRC_ACTIVE, 1024, active source pixels per line and active source lines per frame; power of 2, max 1024.
SRC_HBLANK, 6, idle cycles appended to every source line; total line length is SRC_ACTIVE+SRC_HBLANK.
LINES, 4, ring-buffer depth in lines; power of 2.
CW, 11, coordinate counter width.

Ports:
clk  in  1  scaler clock
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse from output timing, 2 output lines before the vertical active region
frame_active  in  1  level; high while the output frame needs source data
rd_line  in  CW  source line index (integer part of the Y scale) the read side currently blends as its top line
rd_line_strobe  in  1  pulse when the read side begins an output line using rd_line
src_x  out  CW  current source pixel column
src_y  out  CW  current source line
src_req  out  1  requests the pixel at (src_x, src_y); the generator returns data 1 cycle later
wr_en  out  1  line-buffer write enable
wr_addr  out  log2(LINES)+log2(SRC_ACTIVE)  {slot = line mod LINES, column}
stall  out  1  high while waiting for ring-buffer space
line_done  out  1  one-cycle pulse after the last cycle of each source line
frame_done  out  1  one-cycle pulse after the last source line completes
underrun  out  1  sticky read-side underrun flag

Behaviour:
- Reset: all outputs 0; state IDLE; internal pipeline registers cleared.
- States:
  - IDLE: on frame_start, go to GATE with src_x=0, src_y=0 and clear underrun.
  - GATE: line-boundary check. Proceed to FILL when src_y < rd_line+LINES, compared at CW+1 bits with no wrap. Otherwise stay in GATE with stall=1.
  - FILL: src_x counts 0 to SRC_ACTIVE+SRC_HBLANK-1 and never stalls mid-line. src_req=1 only while src_x < SRC_ACTIVE.
  - End of line: on the last cycle, src_x returns to 0 and src_y increments, line_done pulses on the next cycle, and the state goes to GATE. If the finished line was SRC_ACTIVE-1, the state goes to DONE instead and frame_done pulses.
  - DONE: hold with no requests until frame_active=0, then go to IDLE.
- Gate latency: GATE-to-FILL takes 1 cycle. The first src_req of a line follows the cycle in which the gate condition is true. rd_line changes are honoured within 1 cycle.
- Write pipeline: wr_en(t+1)=src_req(t). wr_addr(t+1)={src_y[log2 LINES-1:0], src_x[log2 SRC_ACTIVE-1:0]} as registered at t. Pixel data is not routed through this block.
- Underrun: on rd_line_strobe, underrun is set if the number of completed lines < min(rd_line+2, SRC_ACTIVE) while the state is not IDLE or DONE. Completed lines equals src_y when in GATE, and src_y otherwise. underrun is cleared only by frame_start or reset.
- Abort: frame_active=0 in GATE or FILL goes to IDLE next cycle. src_req, stall and src_x/src_y are zeroed, and the wr_en for a pixel requested in the abort cycle is suppressed.
- Restart: frame_start in any non-IDLE state restarts at GATE/line 0 with underrun cleared. Any in-flight wr_en is suppressed.
- Simultaneous events: frame_start has priority over abort, and abort has priority over end-of-line.
- frame_start and frame_active are both required to start; frame_start with frame_active=0 is ignored.

Test Plan:
- Reset: assert rst_n=0 mid-FILL -> all outputs 0 immediately; after release, no src_req until frame_start.
- Fill to full: frame_start, frame_active=1, rd_line=0 -> 4×1024 wr_en pulses; last write wr_addr={2'b11,10'h3FF}; then stall=1, src_y=4, src_x=0 held.
- Release: with the block stalled, set rd_line=1 -> stall drops within 1 cycle; line 4 writes to slot 0 (first wr_addr=12'h000); stall again at src_y=5.
- Underrun: stalled at src_y=4, pulse rd_line_strobe with rd_line=3 -> underrun=1 and stays set; next frame_start -> underrun=0.
- Full frame: rd_line tracking at src_y-2 -> exactly 1024×1024 wr_en pulses, 1024 line_done pulses, one frame_done; no src_req in DONE until frame_active drops, then IDLE.
- Abort: drop frame_active at src_x=500 of line 2 -> src_req=0 next cycle, no further wr_en beyond column 499, src_x=src_y=0 in IDLE.
